// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: 4-digit common-anode FND driver with serial BCD conversion.
// Optional build macro FND_LZB_EN enables leading-zero blanking.
module fnd_scan_controller #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [3:0]  o_fnd_digit,
    output logic [7:0]  o_fnd_font,
    output logic [1:0]  o_digit_idx,
    output logic        o_overflow
);

    localparam int PW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [15:0]   bcd_adj;
    logic          ovf_pend_q, ovf_pend_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   disp_q, disp_d;
    logic          ovf_q, ovf_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic          wrap;

    logic [3:0]    digit_q, digit_d;
    logic [7:0]    font_q, font_d;
    logic [1:0]    didx_q, didx_d;
    logic          oovf_q, oovf_d;
    logic [3:0]    nib;
`ifdef FND_LZB_EN
    logic          lead_zero;
`endif

    function automatic logic [7:0] seg_font(input logic [3:0] n);
        logic [7:0] f;
        case (n)
            4'd0:    f = 8'hC0;
            4'd1:    f = 8'hF9;
            4'd2:    f = 8'hA4;
            4'd3:    f = 8'hB0;
            4'd4:    f = 8'h99;
            4'd5:    f = 8'h92;
            4'd6:    f = 8'h82;
            4'd7:    f = 8'hF8;
            4'd8:    f = 8'h80;
            4'd9:    f = 8'h90;
            default: f = 8'hFF;
        endcase
        return f;
    endfunction

    assign o_ready = (state_q == S_IDLE);

    // Conversion FSM: latch clamped value, shift-add-3 for 14 cycles, commit.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        bcd_adj    = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    bin_d      = (i_value > 14'd9999) ? 14'd9999 : i_value;
                    ovf_pend_d = (i_value > 14'd9999);
                    bcd_d      = 16'd0;
                    cnt_d      = 4'd0;
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d  = bcd_q;
                ovf_d   = ovf_pend_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Free-running prescaler and scan index, unaffected by conversions.
    always_comb begin
        wrap    = (presc_q == PW'(CLK_DIV - 1));
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    end

    // Output stage: dead-time blanking, font lookup and dp on digit 3.
    always_comb begin
        nib    = disp_q[{idx_q, 2'b00} +: 4];
        font_d = seg_font(nib);
`ifdef FND_LZB_EN
        lead_zero = 1'b0;
        unique case (idx_q)
            2'd1:    lead_zero = (disp_q[15:4] == 12'd0);
            2'd2:    lead_zero = (disp_q[15:8] == 8'd0);
            2'd3:    lead_zero = (disp_q[15:12] == 4'd0);
            default: lead_zero = 1'b0;
        endcase
        if (lead_zero) begin
            font_d = 8'hFF;
        end
`endif
        if (idx_q == 2'd3 && ovf_q) begin
            font_d[7] = 1'b0;
        end
        if (presc_q < PW'(BLANK_CYCLES)) begin
            digit_d = 4'b1111;
        end else begin
            digit_d = ~(4'b0001 << idx_q);
        end
        didx_d = idx_q;
        oovf_d = ovf_q;
    end

    // All state, synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            bin_q      <= 14'd0;
            bcd_q      <= 16'd0;
            ovf_pend_q <= 1'b0;
            cnt_q      <= 4'd0;
            disp_q     <= 16'd0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            idx_q      <= 2'd0;
            digit_q    <= 4'b1111;
            font_q     <= 8'hFF;
            didx_q     <= 2'd0;
            oovf_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            ovf_pend_q <= ovf_pend_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            digit_q    <= digit_d;
            font_q     <= font_d;
            didx_q     <= didx_d;
            oovf_q     <= oovf_d;
        end
    end

    assign o_fnd_digit = digit_q;
    assign o_fnd_font  = font_q;
    assign o_digit_idx = didx_q;
    assign o_overflow  = oovf_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Testbench for fnd_scan_controller: random and directed transfers,
// scoreboard of expected displays checked every output cycle.
module tb_fnd_scan_controller;

    localparam int CD = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [13:0] i_value;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  o_fnd_digit;
    logic [7:0]  o_fnd_font;
    logic [1:0]  o_digit_idx;
    logic        o_overflow;

    fnd_scan_controller #(
        .CLK_DIV      (CD),
        .BLANK_CYCLES (BL)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_value     (i_value),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_fnd_digit (o_fnd_digit),
        .o_fnd_font  (o_fnd_font),
        .o_digit_idx (o_digit_idx),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           ovf;
        logic [3:0][7:0] f;
    } exp_t;

    localparam logic [7:0] FONT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n = 0;
    int   acc_n = 0;
    bit   have_acc = 0;
    bit   started = 0;
    bit   prev_rdy = 1;

    function automatic exp_t expect_of(input int v);
        exp_t e;
        int   c;
        int   p;
        c     = (v > 9999) ? 9999 : v;
        e.ovf = (v > 9999);
        p     = 1;
        for (int k = 0; k < 4; k++) begin
            e.f[k] = FONT[(c / p) % 10];
`ifdef FND_LZB_EN
            if (k > 0 && c < p) e.f[k] = 8'hFF;
`endif
            if (k == 3 && e.ovf) e.f[k][7] = 1'b0;
            p = p * 10;
        end
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, n);
        end
    endtask

    // Reference model: edge count since reset, acceptance, expectation queue.
    always @(posedge clk) begin
        bit rdy;
        if (i_reset) begin
            started  = 1;
            n        = 0;
            have_acc = 0;
            exp_q.delete();
        end else if (started) begin
            rdy = !have_acc || (n - acc_n >= 15);
            n++;
            if (i_valid && rdy) begin
                acc_n    = n;
                have_acc = 1;
                exp_q.push_back(expect_of(int'(i_value)));
            end
        end
    end

    // Monitor: per-cycle check of scan timing and fonts, pops on commit.
    always @(negedge clk) begin
        int         p;
        int         ix;
        logic [3:0] ed;
        if (started) begin
            if (n == 0) begin
                check("rst_digit", 32'(o_fnd_digit), 32'hF);
                check("rst_font", 32'(o_fnd_font), 32'hFF);
                check("rst_idx", 32'(o_digit_idx), 32'd0);
                check("rst_ovf", 32'(o_overflow), 32'd0);
                check("rst_ready", 32'(o_ready), 32'd1);
                cur      = expect_of(0);
                prev_rdy = 1;
            end else begin
                p  = (n - 1) % CD;
                ix = ((n - 1) / CD) % 4;
                ed = (p < BL) ? 4'b1111 : ~(4'b0001 << ix);
                check("digit", 32'(o_fnd_digit), 32'(ed));
                check("idx", 32'(o_digit_idx), 32'(ix));
                check("ready", 32'(o_ready),
                      32'(!have_acc || (n - acc_n >= 15)));
                check("font", 32'(o_fnd_font), 32'(cur.f[ix]));
                check("ovf", 32'(o_overflow), 32'(cur.ovf));
                if (o_ready && !prev_rdy) begin
                    if (exp_q.size() == 0) begin
                        check("commit_unexpected", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                prev_rdy = o_ready;
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (o_ready !== 1'b1 && w < 40) begin
            @(posedge clk);
            #2;
            w++;
        end
        check("ready_timeout", 32'(w >= 40), 32'd0);
    endtask

    task automatic send(input int v);
        wait_ready();
        i_valid = 1'b1;
        i_value = 14'(v);
        @(posedge clk);
        #2;
        i_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_value = 14'd0;
        repeat (3) @(posedge clk);
        #2;
        i_reset = 1'b0;
        idle(40);

        send(1234);  idle(50);
        send(12000); idle(50);
        send(7);     idle(50);
        send(0);     idle(50);

        wait_ready();
        i_valid = 1'b1;
        i_value = 14'd5;
        @(posedge clk);
        #2;
        i_value = 14'd9;
        idle(20);
        i_valid = 1'b0;
        idle(50);

        send(4321);
        idle(4);
        i_reset = 1'b1;
        idle(2);
        i_reset = 1'b0;
        idle(40);
        send(42);
        idle(50);

        for (int i = 0; i < 400; i++) begin
            i_valid = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 3);
            if (r == 0)      i_value = 14'($urandom_range(0, 99));
            else if (r == 1) i_value = 14'($urandom_range(9990, 16383));
            else             i_value = 14'($urandom_range(0, 9999));
            @(posedge clk);
            #2;
        end
        i_valid = 1'b0;
        idle(60);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
- Drives a 4-digit common-anode multiplexed FND from a binary value.
- Accepts a 14-bit binary value over a valid/ready handshake.
- Converts the value to 4 BCD digits sequentially (shift-add-3, one bit per cycle).
- Time-multiplexes the digits with a prescaled 2-bit scan counter and inserts dead-time between digits to suppress ghosting.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all digits off; must be < CLK_DIV.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous reset, active-high.
- i_value  input  14  binary value to display.
- i_valid  input  1  i_value is valid.
- o_ready  output  1  high in IDLE; a transfer occurs when i_valid && o_ready at a rising edge.
- o_fnd_digit  output  4  digit enables, active-low one-hot; bit k = digit k; digit 0 = ones (rightmost).
- o_fnd_font  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- o_digit_idx  output  2  current scan index, registered together with o_fnd_digit.
- o_overflow  output  1  the displayed value was clamped.

Behaviour:
- Reset is synchronous and active-high on i_clk (decided). All state updates on the rising edge of i_clk.
- Reset values:
  - State IDLE; prescaler 0; scan index 0.
  - Display BCD register 0000; overflow 0.
  - o_fnd_digit 4'b1111; o_fnd_font 8'hFF; o_digit_idx 0; o_overflow 0.
  - o_ready = 1 (combinational from state).
- Conversion FSM:
  - IDLE: o_ready = 1. On transfer:
    - Latch min(i_value, 9999) into the shift register.
    - Latch ovf = (i_value > 9999).
    - Clear the BCD accumulator and go to CONV.
  - CONV: 14 cycles. Each cycle, add 3 to every accumulator nibble >= 5, then shift {bcd, bin} left by 1. After the 14th cycle go to COMMIT.
  - COMMIT: 1 cycle. Copy the accumulator to the display register and ovf to the overflow register, then go to IDLE.
  - o_ready is low for exactly 15 cycles after the transfer edge.
  - The display register updates at the 15th edge after the transfer.
  - i_valid while o_ready = 0 is ignored; no queueing.
- Scan:
  - The prescaler counts 0..CLK_DIV-1 and wraps.
  - On wrap, the scan index increments mod 4 (3 -> 0).
  - Scan timing is independent of conversion and loads.
- Output stage (registered, 1-cycle latency from prescaler/index/display):
  - Prescaler < BLANK_CYCLES: o_fnd_digit = 4'b1111.
  - Otherwise: o_fnd_digit = ~(1 << idx).
  - o_fnd_font = font(display digit idx) during both blank and active cycles.
  - o_digit_idx = idx.
  - o_overflow = overflow register.
- Font codes, dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Nibbles above 9 cannot occur; map them to FF.
- DP: low (lit) only on digit 3 when overflow = 1.
- Display-register change mid-slot: the new font appears on the following output cycle; slot timing is unchanged.
- Reset mid-conversion: aborts the conversion. The display returns to 0000, and o_ready = 1 on the first cycle after reset deasserts.
- Reset has priority over a simultaneous transfer.

Optional Feature:
- Macro: FND_LZB_EN (leading-zero blanking).
- Defined: digits above the most significant non-zero digit output font FF (the dp rule still applies to digit 3). Digit 0 is never blanked, so value 0 shows "0" on digit 0 only.
- Undefined: all four digits always display, including leading zeros ("0007").

Test Plan (CLK_DIV=8, BLANK_CYCLES=2):
- Reset held 3 cycles:
  - Outputs 1111/FF, o_ready = 1.
  - After release, slot 0 lights with o_fnd_digit = 1110 and font C0 at prescaler 2 + 1 cycle.
  - Digits step 0 -> 1 -> 2 -> 3 -> 0 every 8 cycles, with 2 blank cycles each slot.
- Transfer 1234:
  - o_ready low for 15 cycles.
  - Then fonts: digit0 = 99, digit1 = B0, digit2 = A4, digit3 = F9; o_overflow = 0.
- Transfer 12000:
  - Clamped to 9999; o_overflow = 1.
  - Digit3 font = 10 (9 with dp lit); digits 0-2 font = 90.
- Transfer 7:
  - FND_LZB_EN defined: digit0 = F8, digits 1-3 = FF.
  - Undefined: digits 1-3 = C0.
  - Transfer 0 with the macro defined: digit0 = C0 only.
- i_valid held high with 5 then 9 (second value during CONV):
  - Only 5 is accepted.
  - o_ready returns high after 15 cycles, then 9 is accepted on that edge.
  - Final display shows 9.
- Transfer 4321, then i_reset at the 5th CONV cycle:
  - Display shows 0000 and o_ready = 1 after release.
  - A new transfer of 42 then displays correctly.
